// File: rtl/logic_gate_pipe.sv
// Bitwise logic unit with a 2-entry in-order result buffer and
// valid/ready handshakes on both sides.
module logic_gate_pipe #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic          red_or,
    output logic          red_and,
    output logic [CW-1:0] done_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic pop;

    logic [W-1:0] res_y;
    logic         res_or;
    logic         res_and;

    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic         or0;
    logic         or1;
    logic         and0;
    logic         and1;

    logic [CW-1:0] cnt;

    always_comb begin
        res_y = '0;
        unique case (op)
            3'b000:  res_y = a & b;
            3'b001:  res_y = a | b;
            3'b010:  res_y = a ^ b;
            3'b011:  res_y = ~(a & b);
            3'b100:  res_y = ~(a | b);
            3'b101:  res_y = ~(a ^ b);
            3'b110:  res_y = a;
            3'b111:  res_y = ~a;
            default: res_y = '0;
        endcase
        res_or  = |res_y;
        res_and = &res_y;
    end

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !pop) begin
                    state_nxt = FULL;
                end else if (pop && !accept) begin
                    state_nxt = EMPTY;
                end
            end
            FULL:  if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Outputs gated by rst_n so nothing leaks while reset is held.
    always_comb begin
        in_ready  = rst_n && (state == EMPTY || state == ONE);
        out_valid = rst_n && (state == ONE || state == FULL);
        y         = out_valid ? y0 : '0;
        red_or    = out_valid ? or0 : 1'b0;
        red_and   = out_valid ? and0 : 1'b0;
        done_cnt  = cnt;
    end

    // Entry 0 is always the head; entry 1 shifts forward on pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y0   <= '0;
            y1   <= '0;
            or0  <= 1'b0;
            or1  <= 1'b0;
            and0 <= 1'b0;
            and1 <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        y0   <= res_y;
                        or0  <= res_or;
                        and0 <= res_and;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        y0   <= res_y;
                        or0  <= res_or;
                        and0 <= res_and;
                    end else if (accept) begin
                        y1   <= res_y;
                        or1  <= res_or;
                        and1 <= res_and;
                    end
                end
                FULL: begin
                    if (pop) begin
                        y0   <= y1;
                        or0  <= or1;
                        and0 <= and1;
                    end
                end
                default: begin
                    y0 <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: a reference model predicts every
// head result, ready/valid level and the wrapping completion counter.
module tb_logic_gate_pipe;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          red_or;
    logic          red_and;
    logic [CW-1:0] done_cnt;

    logic [W+1:0]  sb_q[$];
    logic [CW-1:0] exp_done;
    int            n_cmp;
    int            n_bad;

    logic_gate_pipe #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .red_or    (red_or),
        .red_and   (red_and),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [2:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] z);
        logic [W-1:0] r;
        case (o)
            3'd0: r = x & z;
            3'd1: r = x | z;
            3'd2: r = x ^ z;
            3'd3: r = ~(x & z);
            3'd4: r = ~(x | z);
            3'd5: r = ~(x ^ z);
            3'd6: r = x;
            default: r = ~x;
        endcase
        return {r, |r, &r};
    endfunction

    // Monitor: inputs are stable at the falling edge, so the handshakes
    // seen here are the ones the next rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_head", {22'd0, y, red_or, red_and}, 32'd0);
            sb_q.delete();
            exp_done = '0;
        end else begin
            automatic int  cnt_q = sb_q.size();
            automatic logic do_push = in_valid && cnt_q < 2;
            chk("in_ready", {31'd0, in_ready}, {31'd0, cnt_q < 2});
            chk("out_valid", {31'd0, out_valid}, {31'd0, cnt_q > 0});
            if (cnt_q > 0) begin
                chk("head", {22'd0, y, red_or, red_and}, {22'd0, sb_q[0]});
            end else begin
                chk("idle_head", {22'd0, y, red_or, red_and}, 32'd0);
            end
            chk("done_cnt", {30'd0, done_cnt}, {30'd0, exp_done});
            if (cnt_q > 0 && out_ready) begin
                void'(sb_q.pop_front());
                exp_done = exp_done + 1'b1;
            end
            if (do_push) sb_q.push_back(model(op, a, b));
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] z);
        int budget;
        budget = 200;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = z;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_done = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Single OR transfer
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'b001, 8'hA0, 8'h05);
        chk("or_y", {24'd0, y}, 32'hA5);
        chk("or_red", {30'd0, red_or, red_and}, 32'd2);
        drain();
        chk("first_done", {30'd0, done_cnt}, 32'd1);

        // All eight ops back to back
        for (int i = 0; i < 8; i++) send(i[2:0], 8'hF0, 8'hCC);
        drain();

        // Fill with out_ready low, third held off, then release
        out_ready = 1'b0;
        send(3'd2, 8'h11, 8'h22);
        send(3'd3, 8'h33, 8'h0F);
        fork
            send(3'd5, 8'h5A, 8'hA5);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("full_no_ready", {31'd0, in_ready}, 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random back-pressure
        fork
            for (int i = 0; i < 40; i++) begin
                send(3'($urandom_range(0, 7)), 8'($urandom),
                     8'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            repeat (120) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset while FULL and consumer ready
        out_ready = 1'b0;
        send(3'd6, 8'h77, 8'h00);
        send(3'd7, 8'h3C, 8'h00);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_y", {24'd0, y}, 32'd0);
        chk("post_rst_done", {30'd0, done_cnt}, 32'd0);
        send(3'd0, 8'hFF, 8'h81);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter W, default 8, operand and result width in bits (W >= 1).
REQ-002 Parameter CW, default 16, width of the completed-transfer counter (CW >= 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  operand set a/b/op is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 op  input  3  operation select.
REQ-008 a  input  W  operand A.
REQ-009 b  input  W  operand B.
REQ-010 out_valid  output  1  head result on y/red_or/red_and is valid.
REQ-011 out_ready  input  1  consumer accepts the head result.
REQ-012 y  output  W  bitwise result.
REQ-013 red_or  output  1  OR-reduction of y.
REQ-014 red_and  output  1  AND-reduction of y.
REQ-015 done_cnt  output  CW  count of completed output handshakes.

Function
REQ-016 op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 pass A, 111 NOT A; b is ignored for 110/111.
REQ-017 Input handshake: a transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; a, b and op are sampled only at that edge.
REQ-018 Output handshake: a transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-019 Results SHALL be computed at input acceptance and stored in a 2-entry in-order result buffer holding y, red_or and red_and per entry.
REQ-020 Buffer states SHALL be EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-021 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; ONE stays ONE on simultaneous accept and pop; FULL->ONE on pop.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL, independent of out_ready (no combinational ready path); FULL with a pop SHALL NOT accept in the same cycle.
REQ-023 out_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-024 y, red_or and red_and SHALL present the oldest buffered entry; they are 0 when EMPTY.
REQ-025 Latency: a result accepted at edge N SHALL appear with out_valid=1 from the cycle following edge N.
REQ-026 Throughput SHALL be one transfer per cycle with out_ready held 1.
REQ-027 Head outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 done_cnt SHALL increment by 1 on each output handshake and wrap from 2^CW-1 to 0.
REQ-029 in_valid=1 while in_ready=0 SHALL have no effect; the operands are not captured.
REQ-030 out_ready=1 while out_valid=0 SHALL have no effect.

Reset
REQ-031 With rst_n=0 at a rising edge, the state SHALL become EMPTY, buffer contents 0, done_cnt 0.
REQ-032 While rst_n=0, in_ready, out_valid, y, red_or and red_and SHALL be 0.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n=1 is sampled.
REQ-034 Reset asserted mid-operation (ONE or FULL) SHALL discard all buffered results and SHALL NOT produce a handshake in that cycle.

Verification
REQ-035 W=8, out_ready=1; send op=001, a=8'hA0, b=8'h05 -> next cycle out_valid=1, y=8'hA5, red_or=1, red_and=0, then done_cnt=1.
REQ-036 Cycle all 8 ops with a=8'hF0, b=8'hCC -> y = C0, FC, 3C, 3F, 03, C3, F0, 0F in order, no gaps.
REQ-037 out_ready=0; send 3 sets back-to-back -> in_ready=0 after the 2nd accept, 3rd held off; raise out_ready -> the 3 results emerge in order.
REQ-038 FULL with out_ready=1 and in_valid=1 -> pop occurs, no accept that cycle; in_ready=1 next cycle.
REQ-039 CW=2; perform 5 output handshakes -> done_cnt sequence 1,2,3,0,1.
REQ-040 Assert rst_n=0 in FULL with out_ready=1 -> out_valid=0, done_cnt=0 next cycle, no stale y after release.
